// File: rtl/cam_pkg.sv
// Shared types and constants for the OV7670-style test-pattern transmitter.
package cam_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StVsync,
        StVback,
        StActive,
        StVfront
    } cam_state_e;

    typedef enum logic [1:0] {
        PatBars     = 2'd0,
        PatChecker  = 2'd1,
        PatGradient = 2'd2,
        PatRed      = 2'd3
    } cam_pat_e;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    localparam logic [7:0] FRAME_TAG = 8'hA5;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cam_pattern_gen.sv
// Combinational test-pattern source: active pixel (x, y) and pattern code to RGB565.
module cam_pattern_gen
    import cam_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 160
) (
    input  logic [9:0]  x_i,
    input  logic [9:0]  y_i,
    input  logic [1:0]  pattern_i,
    output logic [15:0] rgb_o
);

    logic [31:0] bar_idx;

    always_comb begin
        bar_idx = ({22'd0, x_i} * 32'd8) / H_ACTIVE;
        rgb_o   = RGB_BLACK;
        case (cam_pat_e'(pattern_i))
            PatBars:     rgb_o = bar_colour((bar_idx > 32'd7) ? 3'd7 : bar_idx[2:0]);
            PatChecker:  rgb_o = (x_i[3] ^ y_i[3]) ? RGB_WHITE : RGB_BLACK;
            PatGradient: rgb_o = {x_i[7:3], y_i[6:1], 5'd0};
            PatRed:      rgb_o = RGB_RED;
            default:     rgb_o = RGB_BLACK;
        endcase
    end

endmodule

// File: rtl/cam_pattern_tx.sv
// Parallel camera-bus transmitter producing RGB565 test frames (pclk = clk/2).
// Optional build macro CAM_TX_FRAME_CNT_EN tags pixel (0,0) with a frame counter.
module cam_pattern_tx
    import cam_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = 160,
    parameter int unsigned V_ACTIVE    = 120,
    parameter int unsigned H_BLANK     = 16,
    parameter int unsigned VSYNC_LINES = 3,
    parameter int unsigned V_BACK      = 17,
    parameter int unsigned V_FRONT     = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] pattern,
    output logic       pclk,
    output logic       vsync,
    output logic       href,
    output logic [7:0] dat,
    output logic       frame_done
);

    localparam int unsigned LineSlots = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned ActSlots  = 2 * H_ACTIVE;
    localparam logic [10:0] LastSlot  = 11'(LineSlots - 1);

    cam_state_e  state_q, state_d;
    logic [10:0] slot_q, slot_d;
    logic [9:0]  line_q, line_d;
    logic [1:0]  pat_q, pat_d;
    logic        pclk_q;
    logic        vsync_q, vsync_d;
    logic        href_q, href_d;
    logic [7:0]  dat_q, dat_d;
    logic        frame_done_q, frame_end;
    logic [9:0]  last_line;
    logic [15:0] rgb, pix;
`ifdef CAM_TX_FRAME_CNT_EN
    logic [7:0]  frame_cnt_q, frame_cnt_d;
`endif

    always_comb begin
        case (state_q)
            StVsync:  last_line = 10'(VSYNC_LINES - 1);
            StVback:  last_line = 10'(V_BACK - 1);
            StActive: last_line = 10'(V_ACTIVE - 1);
            StVfront: last_line = 10'(V_FRONT - 1);
            default:  last_line = '0;
        endcase
    end

    // Timing advances only on the clk edge that drives pclk low (pclk_q currently high).
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        line_d    = line_q;
        pat_d     = pat_q;
        frame_end = 1'b0;
        if (pclk_q) begin
            if (state_q == StIdle) begin
                if (en) begin
                    state_d = StVsync;
                    slot_d  = '0;
                    line_d  = '0;
                    pat_d   = pattern;
                end
            end else if (slot_q != LastSlot) begin
                slot_d = slot_q + 11'd1;
            end else begin
                slot_d = '0;
                if (line_q != last_line) begin
                    line_d = line_q + 10'd1;
                end else begin
                    line_d = '0;
                    case (state_q)
                        StVsync:  state_d = StVback;
                        StVback:  state_d = StActive;
                        StActive: state_d = StVfront;
                        default: begin
                            frame_end = 1'b1;
                            if (en) begin
                                state_d = StVsync;
                                pat_d   = pattern;
                            end else begin
                                state_d = StIdle;
                            end
                        end
                    endcase
                end
            end
        end
    end

    cam_pattern_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_gen (
        .x_i       (slot_d[10:1]),
        .y_i       (line_d),
        .pattern_i (pat_d),
        .rgb_o     (rgb)
    );

    // Outputs are registered from the next-state counters so they line up with the slot.
    always_comb begin
        pix = rgb;
`ifdef CAM_TX_FRAME_CNT_EN
        if (line_d == 10'd0 && slot_d[10:1] == 10'd0) begin
            pix = {FRAME_TAG, frame_cnt_q};
        end
        frame_cnt_d = frame_cnt_q + (frame_end ? 8'd1 : 8'd0);
`endif
        vsync_d = vsync_q;
        href_d  = href_q;
        dat_d   = dat_q;
        if (pclk_q) begin
            vsync_d = (state_d == StVsync);
            href_d  = (state_d == StActive) && (slot_d < 11'(ActSlots));
            dat_d   = href_d ? (slot_d[0] ? pix[7:0] : pix[15:8]) : 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            slot_q       <= '0;
            line_q       <= '0;
            pat_q        <= '0;
            pclk_q       <= 1'b0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            dat_q        <= '0;
            frame_done_q <= 1'b0;
`ifdef CAM_TX_FRAME_CNT_EN
            frame_cnt_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            line_q       <= line_d;
            pat_q        <= pat_d;
            pclk_q       <= ~pclk_q;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            dat_q        <= dat_d;
            frame_done_q <= frame_end;
`ifdef CAM_TX_FRAME_CNT_EN
            frame_cnt_q  <= frame_cnt_d;
`endif
        end
    end

    assign pclk       = pclk_q;
    assign vsync      = vsync_q;
    assign href       = href_q;
    assign dat        = dat_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_cam_pattern_tx.sv
// Bench for cam_pattern_tx: receiver-style monitor with a per-frame scoreboard and pixel table.
module tb_cam_pattern_tx;

    localparam int H_ACT = 160;
    localparam int V_ACT = 9;
    localparam int H_BL  = 16;
    localparam int VS_L  = 2;
    localparam int VB_L  = 1;
    localparam int VF_L  = 1;
    localparam int LINE  = 2 * H_ACT + H_BL;
    localparam int TOTAL = VS_L + VB_L + V_ACT + VF_L;
    localparam int FRAME_CLK = 2 * LINE * TOTAL;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [1:0] pattern = 2'd0;
    logic       pclk, vsync, href, frame_done;
    logic [7:0] dat;

    cam_pattern_tx #(
        .H_ACTIVE    (H_ACT),
        .V_ACTIVE    (V_ACT),
        .H_BLANK     (H_BL),
        .VSYNC_LINES (VS_L),
        .V_BACK      (VB_L),
        .V_FRONT     (VF_L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pattern    (pattern),
        .pclk       (pclk),
        .vsync      (vsync),
        .href       (href),
        .dat        (dat),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pat;
        int cnt;
    } frame_t;

    typedef struct {
        int          f;
        int          x;
        int          y;
        logic [15:0] rgb;
        string       nm;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    frame_t exp_q[$];
    frame_t cur;
    int     push_n = 0;

    int   smp = 0, rise_idx = 0, lines = 0, nframes = 0, fd_cnt = 0, cur_f = 0;
    int   byte_n = 0, zero_viol = 0;
    bit   in_frame = 0, prev_vsync = 0, prev_href = 0, fd_prev = 0;
    logic [7:0]  lb  [0:2*H_ACT-1];
    logic [15:0] cap [0:5][0:V_ACT-1][0:H_ACT-1];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference pixel model written from the pattern definitions.
    function automatic logic [15:0] ref_rgb(input int pat, input int x, input int y, input int cnt);
`ifdef CAM_TX_FRAME_CNT_EN
        if (x == 0 && y == 0) return {8'hA5, 8'(cnt)};
`endif
        case (pat)
            0: begin
                case ((x * 8) / H_ACT)
                    0: return 16'hFFFF;
                    1: return 16'hFFE0;
                    2: return 16'h07FF;
                    3: return 16'h07E0;
                    4: return 16'hF81F;
                    5: return 16'hF800;
                    6: return 16'h001F;
                    default: return 16'h0000;
                endcase
            end
            1: return (((x / 8) % 2) != ((y / 8) % 2)) ? 16'hFFFF : 16'h0000;
            2: return {5'((x / 8) % 32), 6'((y / 2) % 64), 5'd0};
            default: return 16'hF800;
        endcase
    endfunction

    task automatic end_line();
        int          mism;
        logic [15:0] got, exp, fg, fe;
        mism = 0;
        fg = '0;
        fe = '0;
        chk($sformatf("f%0d_y%0d_len", cur_f, lines), byte_n, 2 * H_ACT);
        for (int x = 0; x < H_ACT; x++) begin
            got = {lb[2*x], lb[2*x+1]};
            exp = ref_rgb(cur.pat, x, lines, cur.cnt);
            if (cur_f < 6 && lines < V_ACT) cap[cur_f][lines][x] = got;
            if (got !== exp) begin
                if (mism == 0) begin
                    fg = got;
                    fe = exp;
                end
                mism++;
            end
        end
        n_checks++;
        if (mism != 0) begin
            n_errors++;
            $display("FAIL f%0d_y%0d_data: %0d bad pixels, first got %h expected %h",
                     cur_f, lines, mism, fg, fe);
        end
        lines++;
    endtask

    // Monitor: samples the bus mid pclk-high, as the receiver does on pclk rising.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_frame   = 0;
                prev_vsync = 0;
                prev_href  = 0;
                fd_prev    = 0;
                exp_q.delete();
            end else begin
                if (frame_done) begin
                    chk("frame_done_width", fd_prev, 0);
                    fd_cnt++;
                    if (in_frame) begin
                        chk($sformatf("f%0d_frame_len", cur_f), smp - rise_idx, TOTAL * LINE);
                        chk($sformatf("f%0d_href_pulses", cur_f), lines, V_ACT);
                        chk($sformatf("f%0d_blank_dat", cur_f), zero_viol, 0);
                        in_frame = 0;
                    end
                end
                fd_prev = frame_done;
                if (pclk) begin
                    if (vsync && !prev_vsync) begin
                        chk("scoreboard_not_empty", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) cur = exp_q.pop_front();
                        else cur = '{pat: 3, cnt: 0};
                        in_frame  = 1;
                        rise_idx  = smp;
                        lines     = 0;
                        zero_viol = 0;
                        cur_f     = nframes;
                        nframes++;
                    end
                    if (!vsync && prev_vsync && in_frame)
                        chk($sformatf("f%0d_vsync_len", cur_f), smp - rise_idx, VS_L * LINE);
                    if (in_frame) begin
                        if (vsync && href) zero_viol++;
                        if (href) begin
                            if (!prev_href) begin
                                byte_n = 0;
                                if (lines == 0)
                                    chk($sformatf("f%0d_back_porch", cur_f), smp - rise_idx,
                                        (VS_L + VB_L) * LINE);
                            end
                            if (byte_n < 2 * H_ACT) lb[byte_n] = dat;
                            byte_n++;
                        end else begin
                            if (dat != 8'h00) zero_viol++;
                            if (prev_href) end_line();
                        end
                    end
                    prev_vsync = vsync;
                    prev_href  = href;
                    smp++;
                end
            end
        end
    end

    task automatic set_pat(input int p);
        pattern = 2'(p);
        exp_q.push_back('{pat: p, cnt: push_n});
        push_n++;
    endtask

    task automatic wait_frames(input int target, input string nm);
        int t;
        t = 0;
        while (nframes < target && t < 2 * FRAME_CLK) begin
            @(negedge clk);
            t++;
        end
        chk(nm, nframes >= target, 1);
    endtask

    task automatic wait_lines(input int target, input string nm);
        int t;
        t = 0;
        while (lines < target && t < FRAME_CLK) begin
            @(negedge clk);
            t++;
        end
        chk(nm, lines >= target, 1);
    endtask

    initial begin : driver
        vec_t tbl[$];
        int   bad, highs, t;
        bit   found;

        tbl.push_back('{0, 159, 8, 16'hF800, "f0_red_159_8"});
        tbl.push_back('{1, 19, 0, 16'hFFFF, "f1_bar_white_19"});
        tbl.push_back('{1, 20, 0, 16'hFFE0, "f1_bar_yellow_20"});
        tbl.push_back('{1, 40, 3, 16'h07FF, "f1_bar_cyan_40"});
        tbl.push_back('{1, 60, 5, 16'h07E0, "f1_bar_green_60"});
        tbl.push_back('{1, 80, 0, 16'hF81F, "f1_bar_magenta_80"});
        tbl.push_back('{1, 100, 8, 16'hF800, "f1_bar_red_100"});
        tbl.push_back('{1, 120, 0, 16'h001F, "f1_bar_blue_120"});
        tbl.push_back('{1, 159, 0, 16'h0000, "f1_bar_black_159"});
        tbl.push_back('{2, 100, 6, 16'h6060, "f2_grad_100_6"});
        tbl.push_back('{2, 159, 8, 16'h9880, "f2_grad_159_8"});
        tbl.push_back('{3, 8, 0, 16'hF800, "f3_red_before_change"});
        tbl.push_back('{3, 8, 8, 16'hF800, "f3_red_after_change"});
        tbl.push_back('{4, 8, 0, 16'hFFFF, "f4_check_8_0"});
        tbl.push_back('{4, 7, 0, 16'h0000, "f4_check_7_0"});
        tbl.push_back('{4, 8, 8, 16'h0000, "f4_check_8_8"});
        tbl.push_back('{4, 0, 8, 16'hFFFF, "f4_check_0_8"});
`ifdef CAM_TX_FRAME_CNT_EN
        tbl.push_back('{0, 0, 0, 16'hA500, "f0_tag"});
        tbl.push_back('{1, 0, 0, 16'hA501, "f1_tag"});
        tbl.push_back('{2, 0, 0, 16'hA502, "f2_tag"});
        tbl.push_back('{4, 0, 0, 16'hA504, "f4_tag"});
`else
        tbl.push_back('{0, 0, 0, 16'hF800, "f0_red_0_0"});
        tbl.push_back('{1, 0, 0, 16'hFFFF, "f1_bar_white_0"});
        tbl.push_back('{4, 0, 0, 16'h0000, "f4_check_0_0"});
`endif

        repeat (3) @(negedge clk);
        chk("rst_pclk", pclk, 0);
        chk("rst_vsync", vsync, 0);
        chk("rst_href", href, 0);
        chk("rst_dat", dat, 0);
        chk("rst_frame_done", frame_done, 0);
        rst = 1'b1;

        highs = 0;
        bad   = 0;
        repeat (20) begin
            @(negedge clk);
            if (pclk) highs++;
            if (vsync || href || dat != 8'h00 || frame_done) bad++;
        end
        chk("idle_pclk_highs", highs, 10);
        chk("idle_outputs_low", bad, 0);

        set_pat(3);
        en = 1'b1;
        wait_frames(1, "frame0_start");
        set_pat(0);
        wait_frames(2, "frame1_start");
        set_pat(2);
        wait_frames(3, "frame2_start");
        set_pat(3);
        wait_frames(4, "frame3_start");
        wait_lines(4, "frame3_mid");
        set_pat(1);
        wait_frames(5, "frame4_start");
        wait_lines(2, "frame4_mid");
        en = 1'b0;

        t = 0;
        while (fd_cnt < 5 && t < 2 * FRAME_CLK) begin
            @(negedge clk);
            t++;
        end
        chk("frame_done_count", fd_cnt, 5);
        bad = 0;
        repeat (6 * LINE) begin
            @(negedge clk);
            if (vsync || href || dat != 8'h00 || frame_done) bad++;
        end
        chk("post_en_drop_idle", bad, 0);
        chk("no_new_frame", nframes, 5);

        for (int i = 0; i < tbl.size(); i++)
            chk(tbl[i].nm, cap[tbl[i].f][tbl[i].y][tbl[i].x], tbl[i].rgb);

        set_pat(3);
        en = 1'b1;
        wait_frames(6, "frame5_start");
        found = 0;
        t = 0;
        while (!found && t < FRAME_CLK) begin
            @(negedge clk);
            t++;
            if (href && dat == 8'hF8) found = 1;
        end
        chk("rst_test_active_seen", found, 1);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_pclk", pclk, 0);
        chk("async_rst_vsync", vsync, 0);
        chk("async_rst_href", href, 0);
        chk("async_rst_dat", dat, 0);
        chk("async_rst_frame_done", frame_done, 0);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        highs = 0;
        bad   = 0;
        repeat (4 * LINE) begin
            @(negedge clk);
            if (pclk) highs++;
            if (vsync || href || dat != 8'h00 || frame_done) bad++;
        end
        chk("post_rst_pclk_highs", highs, 2 * LINE);
        chk("post_rst_idle", bad, 0);
        chk("post_rst_no_frame", nframes, 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
